// File: rtl/altair_bus_pkg.sv
// altair_bus_pkg: shared constants and types for the i8080 bus controller.
//   STATUS_*  bit positions inside the latched i8080 status word
//   OP_JMP    opcode fed to the CPU by the boot overlay
//   boot_state_e  boot overlay state encoding
package altair_bus_pkg;

  localparam int STATUS_INP  = 6;
  localparam int STATUS_OUT  = 4;
  localparam int STATUS_MEMR = 7;

  localparam logic [7:0] OP_JMP = 8'hC3;

  typedef enum logic [1:0] {
    BOOT0 = 2'd0,
    BOOT1 = 2'd1,
    BOOT2 = 2'd2,
    RUN   = 2'd3
  } boot_state_e;

endpackage

// File: rtl/altair_boot_fsm.sv
// altair_boot_fsm: turn-key boot overlay. Feeds JMP BOOT_ADDR to the CPU over
// the first three reads, then steps aside for good.
//
// state | meaning
// BOOT0 | supplying JMP opcode (C3)
// BOOT1 | supplying BOOT_ADDR low byte
// BOOT2 | supplying BOOT_ADDR high byte
// RUN   | overlay inactive until next reset
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   cpu_rd         CPU read strobe (advance on its falling edge)
//   boot_active    high while overlay drives read data
//   boot_byte      byte the overlay supplies in the current state
module altair_boot_fsm
  import altair_bus_pkg::*;
#(
  parameter int          BOOT_EN   = 1,
  parameter logic [15:0] BOOT_ADDR = 16'hFD00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_rd,
  output logic       boot_active,
  output logic [7:0] boot_byte
);

  boot_state_e state, state_nxt;
  logic        rd_q;
  logic        rd_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (BOOT_EN != 0) state <= BOOT0;
      else              state <= RUN;
      rd_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_q  <= cpu_rd;
    end
  end

  // Advancing on the falling edge keeps the byte stable for the whole read.
  assign rd_fall = rd_q & ~cpu_rd;

  always_comb begin
    state_nxt = state;
    boot_byte = 8'hFF;
    case (state)
      BOOT0: begin
        boot_byte = OP_JMP;
        if (rd_fall) state_nxt = BOOT1;
      end
      BOOT1: begin
        boot_byte = BOOT_ADDR[7:0];
        if (rd_fall) state_nxt = BOOT2;
      end
      BOOT2: begin
        boot_byte = BOOT_ADDR[15:8];
        if (rd_fall) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign boot_active = (state != RUN);

endmodule

// File: rtl/altair_bus_ctrl.sv
// altair_bus_ctrl: i8080 bus controller. CPU clock enable with wait states,
// status-word latch, priority memory/I/O decode, read-data mux, bank register
// and boot overlay.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cpu_addr/odata/sync/rd/wr_n  CPU bus
//   cpu_ce                       registered CPU clock enable
//   cpu_idata                    read data to CPU
//   mem_rd/mem_we, mem_data_in   per-region strobes and read data
//   io_rd/io_we, io_data_in      per-port strobes and read data
//   bank                         bank select register
//   boot_active                  boot overlay in control of read data
//   status                       latched status word
module altair_bus_ctrl
  import altair_bus_pkg::*;
#(
  parameter int                    NUM_MEM     = 4,
  parameter int                    NUM_IO      = 2,
  parameter logic [8*NUM_MEM-1:0]  MEM_BASE    = {8'hFD, 8'hFB, 8'h20, 8'h00},
  parameter logic [8*NUM_MEM-1:0]  MEM_MASK    = {8'hFF, 8'hFF, 8'hE0, 8'hE0},
  parameter logic [NUM_MEM-1:0]    MEM_RO      = 4'b1000,
  parameter logic [8*NUM_IO-1:0]   IO_BASE     = {8'h10, 8'h00},
  parameter logic [8*NUM_IO-1:0]   IO_MASK     = {8'hFE, 8'hFE},
  parameter int                    WAIT_STATES = 1,
  parameter int                    BOOT_EN     = 1,
  parameter logic [15:0]           BOOT_ADDR   = 16'hFD00,
  parameter int                    BANK_BITS   = 2,
  parameter logic [7:0]            BANK_PORT   = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_odata,
  input  logic                   cpu_sync,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr_n,
  output logic                   cpu_ce,
  output logic [7:0]             cpu_idata,
  output logic [NUM_MEM-1:0]     mem_rd,
  output logic [NUM_MEM-1:0]     mem_we,
  input  logic [NUM_MEM*8-1:0]   mem_data_in,
  output logic [NUM_IO-1:0]      io_rd,
  output logic [NUM_IO-1:0]      io_we,
  input  logic [NUM_IO*8-1:0]    io_data_in,
  output logic [BANK_BITS-1:0]   bank,
  output logic                   boot_active,
  output logic [7:0]             status
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_TC = CW'(WAIT_STATES);

  logic [CW-1:0]      ws_cnt;
  logic [NUM_MEM-1:0] mem_sel;
  logic [NUM_IO-1:0]  io_sel;
  logic               mem_found, io_found;
  logic [7:0]         mem_rdata, io_rdata;
  logic [7:0]         boot_byte;
  logic               io_mode_rd, io_mode_wr;
  logic               bank_wr;

  // CE generator: pulse when counter reaches WAIT_STATES, then wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws_cnt <= '0;
      cpu_ce <= 1'b0;
    end else begin
      cpu_ce <= (ws_cnt == WS_TC);
      ws_cnt <= (ws_cnt == WS_TC) ? '0 : ws_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     status <= 8'h00;
    else if (cpu_sync) status <= cpu_odata;
  end

  assign io_mode_rd = status[STATUS_INP];
  assign io_mode_wr = status[STATUS_OUT];

  assign bank_wr = io_mode_wr & (cpu_addr[7:0] == BANK_PORT) & ~cpu_wr_n & cpu_ce;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    bank <= '0;
    else if (bank_wr) bank <= cpu_odata[BANK_BITS-1:0];
  end

  // Priority decode: first hit from index 0 upward wins.
  always_comb begin
    mem_sel   = '0;
    mem_found = 1'b0;
    mem_rdata = 8'hFF;
    for (int i = 0; i < NUM_MEM; i++) begin
      if (!mem_found && ((cpu_addr[15:8] & MEM_MASK[8*i +: 8]) == MEM_BASE[8*i +: 8])) begin
        mem_found  = 1'b1;
        mem_sel[i] = 1'b1;
        mem_rdata  = mem_data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    io_sel   = '0;
    io_found = 1'b0;
    io_rdata = 8'hFF;
    for (int i = 0; i < NUM_IO; i++) begin
      if (!io_found && ((cpu_addr[7:0] & IO_MASK[8*i +: 8]) == IO_BASE[8*i +: 8])) begin
        io_found  = 1'b1;
        io_sel[i] = 1'b1;
        io_rdata  = io_data_in[8*i +: 8];
      end
    end
  end

  // reset_n gating drops strobes the instant reset asserts, without waiting
  // for the cleared status word to propagate through decode.
  assign mem_rd = (reset_n & cpu_rd & ~io_mode_rd & ~boot_active) ? mem_sel : '0;
  assign mem_we = (reset_n & ~cpu_wr_n & ~io_mode_wr) ? (mem_sel & ~MEM_RO) : '0;
  assign io_rd  = (reset_n & cpu_rd & io_mode_rd) ? io_sel : '0;
  assign io_we  = (reset_n & ~cpu_wr_n & io_mode_wr) ? io_sel : '0;

  always_comb begin
    cpu_idata = 8'hFF;
    if (boot_active)                          cpu_idata = boot_byte;
    else if (io_mode_rd) begin
      if (cpu_addr[7:0] == BANK_PORT)         cpu_idata = 8'(bank);
      else if (io_found)                      cpu_idata = io_rdata;
    end else if (mem_found)                   cpu_idata = mem_rdata;
  end

  altair_boot_fsm #(
    .BOOT_EN   (BOOT_EN),
    .BOOT_ADDR (BOOT_ADDR)
  ) u_boot (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_rd      (cpu_rd),
    .boot_active (boot_active),
    .boot_byte   (boot_byte)
  );

endmodule

// File: tb/tb_altair_bus_ctrl.sv
// Directed bench for altair_bus_ctrl: default-parameter instance for decode,
// boot and bank behaviour, plus WAIT_STATES=2 and WAIT_STATES=0 instances for
// clock-enable timing.
module tb_altair_bus_ctrl;
  import altair_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_sync, cpu_rd, cpu_wr_n;
  logic [31:0] mem_data_in;
  logic [15:0] io_data_in;

  logic        cpu_ce, boot_active;
  logic [7:0]  cpu_idata, status;
  logic [3:0]  mem_rd, mem_we;
  logic [1:0]  io_rd, io_we, bank;

  logic        ce2, ba2, ce0, ba0;
  logic [7:0]  id2, st2, id0, st0;
  logic [3:0]  mr2, mw2, mr0, mw0;
  logic [1:0]  ir2, iw2, bk2, ir0, iw0, bk0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  altair_bus_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_odata(cpu_odata),
    .cpu_sync(cpu_sync), .cpu_rd(cpu_rd), .cpu_wr_n(cpu_wr_n), .cpu_ce(cpu_ce),
    .cpu_idata(cpu_idata), .mem_rd(mem_rd), .mem_we(mem_we), .mem_data_in(mem_data_in),
    .io_rd(io_rd), .io_we(io_we), .io_data_in(io_data_in), .bank(bank),
    .boot_active(boot_active), .status(status)
  );

  altair_bus_ctrl #(.WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_odata(cpu_odata),
    .cpu_sync(cpu_sync), .cpu_rd(cpu_rd), .cpu_wr_n(cpu_wr_n), .cpu_ce(ce2),
    .cpu_idata(id2), .mem_rd(mr2), .mem_we(mw2), .mem_data_in(mem_data_in),
    .io_rd(ir2), .io_we(iw2), .io_data_in(io_data_in), .bank(bk2),
    .boot_active(ba2), .status(st2)
  );

  altair_bus_ctrl #(.WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_odata(cpu_odata),
    .cpu_sync(cpu_sync), .cpu_rd(cpu_rd), .cpu_wr_n(cpu_wr_n), .cpu_ce(ce0),
    .cpu_idata(id0), .mem_rd(mr0), .mem_we(mw0), .mem_data_in(mem_data_in),
    .io_rd(ir0), .io_we(iw0), .io_data_in(io_data_in), .bank(bk0),
    .boot_active(ba0), .status(st0)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read pulse: strobe high for a clock, then low for a clock so the
  // falling edge is registered by the boot overlay.
  task automatic rd_pulse_check(input string tag, input logic [7:0] exp_data);
    cpu_rd = 1'b1;
    tick();
    check({tag, "_idata"}, {8'h00, cpu_idata}, {8'h00, exp_data});
    check({tag, "_mem_rd"}, {12'h000, mem_rd}, 16'h0000);
    cpu_rd = 1'b0;
    tick();
  endtask

  initial begin
    logic [2:0] exp_ce2;
    int         budget;

    reset_n     = 1'b0;
    cpu_addr    = 16'h1234;
    cpu_odata   = 8'h00;
    cpu_sync    = 1'b0;
    cpu_rd      = 1'b0;
    cpu_wr_n    = 1'b1;
    mem_data_in = {8'hD3, 8'hC2, 8'hB1, 8'h5A};
    io_data_in  = {8'h77, 8'h66};
    #12;

    check("rst_ce",     {15'h0, cpu_ce}, 16'h0000);
    check("rst_status", {8'h00, status}, 16'h0000);
    check("rst_bank",   {14'h0, bank},   16'h0000);
    check("rst_boot",   {15'h0, boot_active}, 16'h0001);
    check("rst_idata",  {8'h00, cpu_idata}, 16'h00C3);

    // CE timing: release on a falling edge, count posedges from there.
    @(negedge clk);
    reset_n = 1'b1;
    exp_ce2 = 3'b100;
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("ce_ws2_e%0d", e + 1), {15'h0, ce2}, {15'h0, exp_ce2[e % 3]});
      check($sformatf("ce_ws0_e%0d", e + 1), {15'h0, ce0}, 16'h0001);
      check($sformatf("ce_ws1_e%0d", e + 1), {15'h0, cpu_ce}, {15'h0, (e % 2 == 1) ? 1'b1 : 1'b0});
    end

    // Boot overlay on an address that would otherwise hit region 0.
    rd_pulse_check("boot0", 8'hC3);
    rd_pulse_check("boot1", 8'h00);
    check("boot_still_active", {15'h0, boot_active}, 16'h0001);
    rd_pulse_check("boot2", 8'hFD);
    check("boot_done", {15'h0, boot_active}, 16'h0000);

    // Memory read decode with status 00.
    cpu_addr = 16'h1234;
    cpu_rd   = 1'b1;
    #1;
    check("mem_rd_r0",    {12'h0, mem_rd}, 16'h0001);
    check("mem_idata_r0", {8'h00, cpu_idata}, 16'h005A);
    cpu_addr = 16'h2100;
    #1;
    check("mem_rd_r1",    {12'h0, mem_rd}, 16'h0002);
    check("mem_idata_r1", {8'h00, cpu_idata}, 16'h00B1);
    cpu_addr = 16'h8000;
    #1;
    check("unmapped_idata", {8'h00, cpu_idata}, 16'h00FF);
    check("unmapped_rd",    {12'h0, mem_rd}, 16'h0000);
    cpu_rd = 1'b0;

    // Writes: read-only region dropped, RAM region enabled.
    cpu_wr_n = 1'b0;
    cpu_addr = 16'hFD10;
    #1;
    check("we_ro", {12'h0, mem_we}, 16'h0000);
    cpu_addr = 16'hFB10;
    #1;
    check("we_ram", {12'h0, mem_we}, 16'h0004);
    cpu_wr_n = 1'b1;
    tick();

    // I/O read: sync with INP status.
    cpu_odata = 8'h40;
    cpu_sync  = 1'b1;
    tick();
    cpu_sync  = 1'b0;
    check("status_inp", {8'h00, status}, 16'h0040);
    cpu_addr = 16'h1111;
    cpu_rd   = 1'b1;
    #1;
    check("io_rd_p1",    {14'h0, io_rd}, 16'h0002);
    check("io_idata_p1", {8'h00, cpu_idata}, 16'h0077);
    check("io_mem_rd",   {12'h0, mem_rd}, 16'h0000);
    cpu_rd = 1'b0;
    tick();

    // Bank write: sync OUT status, then write on a ce clock.
    cpu_odata = 8'h10;
    cpu_sync  = 1'b1;
    tick();
    cpu_sync  = 1'b0;
    budget = 0;
    while (cpu_ce !== 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    check("ce_wait_bound", {15'h0, cpu_ce}, 16'h0001);
    cpu_addr  = 16'hFFFF;
    cpu_odata = 8'h03;
    cpu_wr_n  = 1'b0;
    #1;
    check("bank_io_we",  {14'h0, io_we}, 16'h0000);
    check("bank_mem_we", {12'h0, mem_we}, 16'h0000);
    tick();
    cpu_wr_n = 1'b1;
    check("bank_written", {14'h0, bank}, 16'h0003);

    // Read the bank register back through its port.
    cpu_odata = 8'h40;
    cpu_sync  = 1'b1;
    tick();
    cpu_sync  = 1'b0;
    cpu_addr  = 16'h00FF;
    cpu_rd    = 1'b1;
    #1;
    check("bank_readback", {8'h00, cpu_idata}, 16'h0003);
    cpu_rd = 1'b0;
    tick();

    // Reset mid-boot: restart, step into BOOT1, then reset asynchronously.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    cpu_addr = 16'h1234;
    rd_pulse_check("reboot0", 8'hC3);
    cpu_odata = 8'h40;
    cpu_sync  = 1'b1;
    tick();
    cpu_sync  = 1'b0;
    check("boot1_idata", {8'h00, cpu_idata}, 16'h0000);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_status", {8'h00, status}, 16'h0000);
    check("async_idata",  {8'h00, cpu_idata}, 16'h00C3);
    check("async_ce",     {15'h0, cpu_ce}, 16'h0000);
    check("async_bank",   {14'h0, bank}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    rd_pulse_check("after_rst", 8'hC3);
    check("after_rst_status", {8'h00, status}, 16'h0000);
    check("after_rst_bank",   {14'h0, bank}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
